cp0_tlb_regs: RTL and testbench

Parametrised CP0 TLB-management register file: Index, Random, EntryLo0/1, Context, PageMask, Wired, EntryHi, BadVAddr. It generalises the fixed 16-entry, 4 KB-page CP0 TLB registers to any power-of-two TLB depth and ASID width. It adds a wrapping Random counter and optional variable page size. It sits beside the CP0 status/cause block, is written by MTC0 and by the TLBP/TLBR/exception commit in MEM, and feeds the TLB write/probe ports.

---
 rtl/cp0_pkg.sv | 32 +++
 rtl/cp0_random_ctr.sv | 37 +++
 rtl/cp0_tlb_regs.sv | 196 +++++++++++++++++++
 tb/tb_cp0_tlb_regs.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// CP0 register addresses, exception codes and TLB register field positions.
// This package is shared by every CP0 block.
package cp0_pkg;

    // Register addresses as {rd[4:0], sel[2:0]}.
    localparam logic [7:0] CP0_INDEX    = {5'd0,  3'd0};
    localparam logic [7:0] CP0_RANDOM   = {5'd1,  3'd0};
    localparam logic [7:0] CP0_ENTRYLO0 = {5'd2,  3'd0};
    localparam logic [7:0] CP0_ENTRYLO1 = {5'd3,  3'd0};
    localparam logic [7:0] CP0_CONTEXT  = {5'd4,  3'd0};
    localparam logic [7:0] CP0_PAGEMASK = {5'd5,  3'd0};
    localparam logic [7:0] CP0_WIRED    = {5'd6,  3'd0};
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_ENTRYHI  = {5'd10, 3'd0};

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int INDEX_P_BIT      = 31;
    localparam int ENTRYLO_W        = 26;
    localparam int ENTRYHI_VPN2_LSB = 13;
    localparam int VPN2_W           = 19;
    localparam int CTX_BADVPN2_LSB  = 4;
    localparam int CTX_PTEBASE_LSB  = 23;
    localparam int PTEBASE_W        = 9;
    localparam int PAGEMASK_LSB     = 13;
    localparam int PAGEMASK_W       = 12;

endpackage

// File: rtl/cp0_random_ctr.sv
// Random register: counts down each cycle from TLB_ENTRIES-1 to Wired, then wraps.
// A Wired write restarts the count from the top.
module cp0_random_ctr #(
    parameter int TLB_ENTRIES = 16,
    localparam int IDX_W = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);

    logic [IDX_W-1:0] random_q;
    logic [IDX_W-1:0] random_d;

    // '<=' rather than '==' keeps the counter from ever sliding under Wired.
    always_comb begin
        random_d = random_q - 1'b1;
        if (wired_we || random_q <= wired) begin
            random_d = TOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            random_q <= TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random = random_q;

endmodule

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB-management registers: Index, Random, EntryLo0/1, Context, PageMask,
// Wired, EntryHi, BadVAddr. Fields are stored individually; reads re-pack them.
module cp0_tlb_regs
    import cp0_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int ASID_W      = 8,
    parameter bit PAGEMASK_EN = 1'b0,
    localparam int IDX_W = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cp0_we,
    input  logic [7:0]       addr,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    input  logic             tlbp_we,
    input  logic             tlbp_found,
    input  logic [IDX_W-1:0] tlbp_idx,
    input  logic             tlbr_we,
    input  logic [31:0]      tlbr_entryhi,
    input  logic [31:0]      tlbr_entrylo0,
    input  logic [31:0]      tlbr_entrylo1,
    input  logic [31:0]      tlbr_pagemask,
    input  logic             tlb_exc,
    input  logic             adr_exc,
    input  logic [31:0]      badvaddr,
    output logic [IDX_W-1:0] index_out,
    output logic [IDX_W-1:0] random_out,
    output logic [31:0]      entryhi_out,
    output logic [31:0]      entrylo0_out,
    output logic [31:0]      entrylo1_out,
    output logic [31:0]      pagemask_out
);

    logic [IDX_W-1:0]      index_q,    index_d;
    logic                  p_q,        p_d;
    logic [ENTRYLO_W-1:0]  entrylo0_q, entrylo0_d;
    logic [ENTRYLO_W-1:0]  entrylo1_q, entrylo1_d;
    logic [VPN2_W-1:0]     vpn2_q,     vpn2_d;
    logic [ASID_W-1:0]     asid_q,     asid_d;
    logic [PTEBASE_W-1:0]  ptebase_q,  ptebase_d;
    logic [VPN2_W-1:0]     badvpn2_q,  badvpn2_d;
    logic [PAGEMASK_W-1:0] pagemask_q, pagemask_d;
    logic [IDX_W-1:0]      wired_q,    wired_d;
    logic [31:0]           badvaddr_q, badvaddr_d;

    logic                  wired_we;
    logic [IDX_W-1:0]      random;
    logic [31:0]           index_word;
    logic [31:0]           entryhi_word;
    logic [31:0]           pagemask_word;
    logic [31:0]           context_word;

    assign wired_we = cp0_we && (addr == CP0_WIRED);

    // Assignments go lowest priority first so later ones win per field.
    always_comb begin
        index_d    = index_q;
        p_d        = p_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        vpn2_d     = vpn2_q;
        asid_d     = asid_q;
        ptebase_d  = ptebase_q;
        badvpn2_d  = badvpn2_q;
        pagemask_d = pagemask_q;
        wired_d    = wired_q;
        badvaddr_d = badvaddr_q;

        if (cp0_we) begin
            case (addr)
                CP0_INDEX:    index_d    = data_in[IDX_W-1:0];
                CP0_ENTRYLO0: entrylo0_d = data_in[ENTRYLO_W-1:0];
                CP0_ENTRYLO1: entrylo1_d = data_in[ENTRYLO_W-1:0];
                CP0_CONTEXT:  ptebase_d  = data_in[CTX_PTEBASE_LSB +: PTEBASE_W];
                CP0_ENTRYHI: begin
                    vpn2_d = data_in[ENTRYHI_VPN2_LSB +: VPN2_W];
                    asid_d = data_in[ASID_W-1:0];
                end
                CP0_PAGEMASK: begin
                    if (PAGEMASK_EN) pagemask_d = data_in[PAGEMASK_LSB +: PAGEMASK_W];
                end
                CP0_WIRED: begin
                    if (data_in < 32'(TLB_ENTRIES)) wired_d = data_in[IDX_W-1:0];
                end
                default: ;
            endcase
        end

        if (tlbp_we) begin
            if (tlbp_found) begin
                index_d = tlbp_idx;
                p_d     = 1'b0;
            end else begin
                p_d     = 1'b1;
            end
        end

        if (tlbr_we) begin
            vpn2_d     = tlbr_entryhi[ENTRYHI_VPN2_LSB +: VPN2_W];
            asid_d     = tlbr_entryhi[ASID_W-1:0];
            entrylo0_d = tlbr_entrylo0[ENTRYLO_W-1:0];
            entrylo1_d = tlbr_entrylo1[ENTRYLO_W-1:0];
            if (PAGEMASK_EN) pagemask_d = tlbr_pagemask[PAGEMASK_LSB +: PAGEMASK_W];
        end

        if (tlb_exc) begin
            vpn2_d    = badvaddr[ENTRYHI_VPN2_LSB +: VPN2_W];
            badvpn2_d = badvaddr[ENTRYHI_VPN2_LSB +: VPN2_W];
        end

        if (tlb_exc || adr_exc) begin
            badvaddr_d = badvaddr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            index_q    <= '0;
            p_q        <= 1'b0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            vpn2_q     <= '0;
            asid_q     <= '0;
            ptebase_q  <= '0;
            badvpn2_q  <= '0;
            pagemask_q <= '0;
            wired_q    <= '0;
            badvaddr_q <= '0;
        end else begin
            index_q    <= index_d;
            p_q        <= p_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            vpn2_q     <= vpn2_d;
            asid_q     <= asid_d;
            ptebase_q  <= ptebase_d;
            badvpn2_q  <= badvpn2_d;
            pagemask_q <= pagemask_d;
            wired_q    <= wired_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    cp0_random_ctr #(
        .TLB_ENTRIES(TLB_ENTRIES)
    ) u_random (
        .clk      (clk),
        .rst      (rst),
        .wired    (wired_q),
        .wired_we (wired_we),
        .random   (random)
    );

    always_comb begin
        index_word                          = '0;
        index_word[INDEX_P_BIT]             = p_q;
        index_word[IDX_W-1:0]               = index_q;
        entryhi_word                        = '0;
        entryhi_word[ENTRYHI_VPN2_LSB +: VPN2_W] = vpn2_q;
        entryhi_word[ASID_W-1:0]            = asid_q;
        pagemask_word                       = '0;
        pagemask_word[PAGEMASK_LSB +: PAGEMASK_W] = pagemask_q;
        context_word                        = '0;
        context_word[CTX_PTEBASE_LSB +: PTEBASE_W] = ptebase_q;
        context_word[CTX_BADVPN2_LSB +: VPN2_W]    = badvpn2_q;
    end

    always_comb begin
        case (addr)
            CP0_INDEX:    data_out = index_word;
            CP0_RANDOM:   data_out = 32'(random);
            CP0_ENTRYLO0: data_out = 32'(entrylo0_q);
            CP0_ENTRYLO1: data_out = 32'(entrylo1_q);
            CP0_CONTEXT:  data_out = context_word;
            CP0_PAGEMASK: data_out = pagemask_word;
            CP0_WIRED:    data_out = 32'(wired_q);
            CP0_BADVADDR: data_out = badvaddr_q;
            CP0_ENTRYHI:  data_out = entryhi_word;
            default:      data_out = '0;
        endcase
    end

    assign index_out    = index_q;
    assign random_out   = random;
    assign entryhi_out  = entryhi_word;
    assign entrylo0_out = 32'(entrylo0_q);
    assign entrylo1_out = 32'(entrylo1_q);
    assign pagemask_out = pagemask_word;

    // Read-back bits outside the writable fields are dropped by design.
    logic unused_tlbr_bits;
    assign unused_tlbr_bits = ^{tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1, tlbr_pagemask};

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Directed bench for cp0_tlb_regs: one DUT with PageMask disabled, one with it enabled,
// both 16 entries, sharing every input.
module tb_cp0_tlb_regs;
    import cp0_pkg::*;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cp0_we;
    logic [7:0]       addr;
    logic [31:0]      data_in;
    logic             tlbp_we;
    logic             tlbp_found;
    logic [IDX_W-1:0] tlbp_idx;
    logic             tlbr_we;
    logic [31:0]      tlbr_entryhi;
    logic [31:0]      tlbr_entrylo0;
    logic [31:0]      tlbr_entrylo1;
    logic [31:0]      tlbr_pagemask;
    logic             tlb_exc;
    logic             adr_exc;
    logic [31:0]      badvaddr;

    logic [31:0]      data_out0,     data_out1;
    logic [IDX_W-1:0] index_out0,    index_out1;
    logic [IDX_W-1:0] random_out0,   random_out1;
    logic [31:0]      entryhi_out0,  entryhi_out1;
    logic [31:0]      entrylo0_out0, entrylo0_out1;
    logic [31:0]      entrylo1_out0, entrylo1_out1;
    logic [31:0]      pagemask_out0, pagemask_out1;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    cp0_tlb_regs #(.TLB_ENTRIES(N), .ASID_W(8), .PAGEMASK_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cp0_we(cp0_we), .addr(addr), .data_in(data_in),
        .data_out(data_out0), .tlbp_we(tlbp_we), .tlbp_found(tlbp_found),
        .tlbp_idx(tlbp_idx), .tlbr_we(tlbr_we), .tlbr_entryhi(tlbr_entryhi),
        .tlbr_entrylo0(tlbr_entrylo0), .tlbr_entrylo1(tlbr_entrylo1),
        .tlbr_pagemask(tlbr_pagemask), .tlb_exc(tlb_exc), .adr_exc(adr_exc),
        .badvaddr(badvaddr), .index_out(index_out0), .random_out(random_out0),
        .entryhi_out(entryhi_out0), .entrylo0_out(entrylo0_out0),
        .entrylo1_out(entrylo1_out0), .pagemask_out(pagemask_out0)
    );

    cp0_tlb_regs #(.TLB_ENTRIES(N), .ASID_W(8), .PAGEMASK_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cp0_we(cp0_we), .addr(addr), .data_in(data_in),
        .data_out(data_out1), .tlbp_we(tlbp_we), .tlbp_found(tlbp_found),
        .tlbp_idx(tlbp_idx), .tlbr_we(tlbr_we), .tlbr_entryhi(tlbr_entryhi),
        .tlbr_entrylo0(tlbr_entrylo0), .tlbr_entrylo1(tlbr_entrylo1),
        .tlbr_pagemask(tlbr_pagemask), .tlb_exc(tlb_exc), .adr_exc(adr_exc),
        .badvaddr(badvaddr), .index_out(index_out1), .random_out(random_out1),
        .entryhi_out(entryhi_out1), .entrylo0_out(entrylo0_out1),
        .entrylo1_out(entrylo1_out1), .pagemask_out(pagemask_out1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        cp0_we = 1'b0; tlbp_we = 1'b0; tlbp_found = 1'b0; tlbr_we = 1'b0;
        tlb_exc = 1'b0; adr_exc = 1'b0;
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        cp0_we = 1'b1; addr = a; data_in = d;
        step();
        cp0_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d0, output logic [31:0] d1);
        addr = a;
        #1;
        d0 = data_out0;
        d1 = data_out1;
    endtask

    task automatic test_reset();
        logic [7:0]  regs [9];
        logic [31:0] d0, d1;
        regs = '{CP0_INDEX, CP0_RANDOM, CP0_ENTRYLO0, CP0_ENTRYLO1, CP0_CONTEXT,
                 CP0_PAGEMASK, CP0_WIRED, CP0_BADVADDR, CP0_ENTRYHI};
        rst = 1'b0;
        clear_strobes();
        addr = 8'h00; data_in = '0; tlbp_idx = '0; badvaddr = '0;
        tlbr_entryhi = '0; tlbr_entrylo0 = '0; tlbr_entrylo1 = '0; tlbr_pagemask = '0;
        step(); step();
        for (int i = 0; i < 9; i++) begin
            rd(regs[i], d0, d1);
            n_cmp++;
            if (d0 !== ((regs[i] == CP0_RANDOM) ? 32'd15 : 32'd0) ||
                d1 !== ((regs[i] == CP0_RANDOM) ? 32'd15 : 32'd0)) begin
                n_err++;
                $display("FAIL reset_reg_%02h: got %08h/%08h", regs[i], d0, d1);
            end
        end
        n_cmp++;
        if (random_out0 !== 4'd15 || index_out0 !== 4'd0 || entryhi_out0 !== 32'd0 ||
            entrylo0_out0 !== 32'd0 || entrylo1_out0 !== 32'd0 || pagemask_out1 !== 32'd0) begin
            n_err++;
            $display("FAIL reset_ports: random=%0d index=%0d ehi=%08h", random_out0, index_out0, entryhi_out0);
        end
    endtask

    task automatic test_random_free_run();
        logic [31:0] d0, d1;
        logic [31:0] exp;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp = 32'((15 - i) & 15);
            rd(CP0_RANDOM, d0, d1);
            n_cmp++;
            if (d0 !== exp || d1 !== exp) begin
                n_err++;
                $display("FAIL random_run_%0d: got %0d/%0d expected %0d", i, d0, d1, exp);
            end
            step();
        end
    endtask

    task automatic test_wired();
        logic [31:0] d0, d1;
        logic [31:0] exp;
        mtc0(CP0_WIRED, 32'd5);
        for (int k = 0; k <= 11; k++) begin
            exp = (k == 11) ? 32'd15 : 32'(15 - k);
            rd(CP0_RANDOM, d0, d1);
            n_cmp++;
            if (d0 !== exp || random_out0 !== exp[3:0]) begin
                n_err++;
                $display("FAIL wired5_random_%0d: got %0d expected %0d", k, d0, exp);
            end
            step();
        end
        mtc0(CP0_WIRED, 32'd16);
        rd(CP0_RANDOM, d0, d1);
        n_cmp++;
        if (d0 !== 32'd15) begin
            n_err++;
            $display("FAIL wired16_random: got %0d expected 15", d0);
        end
        rd(CP0_WIRED, d0, d1);
        n_cmp++;
        if (d0 !== 32'd5) begin
            n_err++;
            $display("FAIL wired16_kept: got %0d expected 5", d0);
        end
        step();
        rd(CP0_RANDOM, d0, d1);
        n_cmp++;
        if (d0 !== 32'd14) begin
            n_err++;
            $display("FAIL wired16_decrement: got %0d expected 14", d0);
        end
        mtc0(CP0_WIRED, 32'd15);
        step(); step();
        rd(CP0_RANDOM, d0, d1);
        n_cmp++;
        if (d0 !== 32'd15) begin
            n_err++;
            $display("FAIL wired15_hold: got %0d expected 15", d0);
        end
        mtc0(CP0_WIRED, 32'd0);
    endtask

    task automatic test_tlbp();
        logic [31:0] d0, d1;
        mtc0(CP0_INDEX, 32'd3);
        tlbp_we = 1'b1; tlbp_found = 1'b0;
        step();
        clear_strobes();
        rd(CP0_INDEX, d0, d1);
        n_cmp++;
        if (d0 !== 32'h8000_0003) begin
            n_err++;
            $display("FAIL tlbp_miss: got %08h expected 80000003", d0);
        end
        tlbp_we = 1'b1; tlbp_found = 1'b1; tlbp_idx = 4'd7;
        step();
        clear_strobes();
        rd(CP0_INDEX, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0000_0007 || index_out0 !== 4'd7) begin
            n_err++;
            $display("FAIL tlbp_hit: got %08h port %0d expected 00000007", d0, index_out0);
        end
        // Probe hit and MTC0 Index in the same cycle: probe wins.
        tlbp_we = 1'b1; tlbp_found = 1'b1; tlbp_idx = 4'd2;
        mtc0(CP0_INDEX, 32'd9);
        clear_strobes();
        rd(CP0_INDEX, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL tlbp_over_mtc0: got %08h expected 00000002", d0);
        end
        mtc0(CP0_INDEX, 32'hFFFF_FFFF);
        rd(CP0_INDEX, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0000_000F) begin
            n_err++;
            $display("FAIL index_mask: got %08h expected 0000000f", d0);
        end
    endtask

    task automatic test_exceptions();
        logic [31:0] d0, d1;
        mtc0(CP0_ENTRYHI, 32'h0000_002A);
        tlb_exc = 1'b1; badvaddr = 32'h1234_5678;
        step();
        clear_strobes();
        rd(CP0_ENTRYHI, d0, d1);
        n_cmp++;
        if (d0 !== 32'h1234_402A || entryhi_out0 !== 32'h1234_402A) begin
            n_err++;
            $display("FAIL tlbexc_entryhi: got %08h expected 1234402a", d0);
        end
        rd(CP0_BADVADDR, d0, d1);
        n_cmp++;
        if (d0 !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL tlbexc_badvaddr: got %08h expected 12345678", d0);
        end
        rd(CP0_CONTEXT, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0009_1A20) begin
            n_err++;
            $display("FAIL tlbexc_context: got %08h expected 00091a20", d0);
        end
        adr_exc = 1'b1; badvaddr = 32'hDEAD_BEEF;
        step();
        clear_strobes();
        rd(CP0_BADVADDR, d0, d1);
        n_cmp++;
        if (d0 !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL adrexc_badvaddr: got %08h expected deadbeef", d0);
        end
        rd(CP0_ENTRYHI, d0, d1);
        n_cmp++;
        if (d0 !== 32'h1234_402A) begin
            n_err++;
            $display("FAIL adrexc_entryhi: got %08h expected 1234402a", d0);
        end
        tlb_exc = 1'b1; badvaddr = 32'h0000_2000;
        mtc0(CP0_ENTRYHI, 32'hFFFF_E0FF);
        clear_strobes();
        rd(CP0_ENTRYHI, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0000_20FF) begin
            n_err++;
            $display("FAIL exc_vs_mtc0_entryhi: got %08h expected 000020ff", d0);
        end
        mtc0(CP0_CONTEXT, 32'hFFFF_FFFF);
        rd(CP0_CONTEXT, d0, d1);
        n_cmp++;
        if (d0 !== 32'hFF80_0010) begin
            n_err++;
            $display("FAIL context_mask: got %08h expected ff800010", d0);
        end
        mtc0(CP0_BADVADDR, 32'h0);
        rd(CP0_BADVADDR, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0000_2000) begin
            n_err++;
            $display("FAIL badvaddr_readonly: got %08h expected 00002000", d0);
        end
    endtask

    task automatic test_masks();
        logic [31:0] d0, d1;
        mtc0(CP0_PAGEMASK, 32'h01FF_E000);
        rd(CP0_PAGEMASK, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0 || d1 !== 32'h01FF_E000 || pagemask_out1 !== 32'h01FF_E000) begin
            n_err++;
            $display("FAIL pagemask: got %08h/%08h expected 00000000/01ffe000", d0, d1);
        end
        mtc0(CP0_ENTRYLO0, 32'hFFFF_FFFF);
        rd(CP0_ENTRYLO0, d0, d1);
        n_cmp++;
        if (d0 !== 32'h03FF_FFFF || entrylo0_out0 !== 32'h03FF_FFFF) begin
            n_err++;
            $display("FAIL entrylo0_mask: got %08h expected 03ffffff", d0);
        end
        mtc0(CP0_ENTRYLO1, 32'h1234_5678);
        rd(CP0_ENTRYLO1, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0234_5678) begin
            n_err++;
            $display("FAIL entrylo1_mask: got %08h expected 02345678", d0);
        end
        rd(8'h01, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0 || d1 !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_read: got %08h/%08h expected 0", d0, d1);
        end
    endtask

    task automatic test_tlbr();
        logic [31:0] d0, d1;
        tlbr_we = 1'b1;
        tlbr_entryhi = 32'hFFFF_FFFF; tlbr_entrylo0 = 32'h0000_0000;
        tlbr_entrylo1 = 32'h0000_0041; tlbr_pagemask = 32'hFFFF_6000;
        mtc0(CP0_ENTRYLO1, 32'h0000_0003);
        clear_strobes();
        n_cmp++;
        if (entryhi_out0 !== 32'hFFFF_E0FF || entrylo0_out0 !== 32'h0 ||
            entrylo1_out0 !== 32'h41) begin
            n_err++;
            $display("FAIL tlbr_load: ehi=%08h lo0=%08h lo1=%08h expected ffffe0ff/0/41",
                     entryhi_out0, entrylo0_out0, entrylo1_out0);
        end
        rd(CP0_PAGEMASK, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0 || d1 !== 32'h01FF_6000) begin
            n_err++;
            $display("FAIL tlbr_pagemask: got %08h/%08h expected 00000000/01ff6000", d0, d1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1;
        mtc0(CP0_ENTRYLO0, 32'h0000_00AA);
        mtc0(CP0_ENTRYLO0, 32'h0000_0055);
        rd(CP0_ENTRYLO0, d0, d1);
        n_cmp++;
        if (d0 !== 32'h55) begin
            n_err++;
            $display("FAIL back_to_back: got %08h expected 00000055", d0);
        end
        // Reset with a write pending: reset wins.
        rst = 1'b0;
        mtc0(CP0_ENTRYLO0, 32'h0000_0077);
        rst = 1'b1;
        rd(CP0_ENTRYLO0, d0, d1);
        n_cmp++;
        if (d0 !== 32'h0 || random_out0 !== 4'd15 || entryhi_out0 !== 32'h0) begin
            n_err++;
            $display("FAIL midop_reset: lo0=%08h random=%0d ehi=%08h", d0, random_out0, entryhi_out0);
        end
    endtask

    initial begin
        test_reset();
        test_random_free_run();
        test_wired();
        test_tlbp();
        test_exceptions();
        test_masks();
        test_tlbr();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
